// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports and the memory-side bus of the arbiter.
// slave modport: the arbiter. master modport: the requesters plus the memory.
// Plain wires only; no storage or timing lives in the interface.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 14
);
   logic              req0, req1;
   logic              we0, we1;
   logic              lock0, lock1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [15:0]       wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [15:0]       rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic [15:0]       mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1,
      input  addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
      output mem_addr, mem_wdata, mem_wr_en, mem_rd_en
   );

   modport master (
      output req0, req1, we0, we1, lock0, lock1,
      output addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata,
      input  mem_addr, mem_wdata, mem_wr_en, mem_rd_en
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters.
// Latency: grant one cycle after request from IDLE; read data RD_LATENCY after issue.
// Backpressure: a requester holds req until it sees gnt; one access per req&&gnt cycle.
module mem_port_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int RD_LATENCY = 1,
   parameter int MAX_HOLD   = 16
) (
   input logic              clk,
   input logic              resetn,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic [7:0]        hold_q, hold_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [RD_LATENCY-1:0] rv_q;   // read-return valid per pipe stage
   logic [RD_LATENCY-1:0] rp_q;   // read-return port per pipe stage

   logic              cur_port;
   logic              own_req, oth_req, own_we, own_lock;
   logic [ADDR_W-1:0] own_addr;
   logic [15:0]       own_wdata;
   logic              issue, rel;
   logic [7:0]        hold_inc;

   // Select the owning port's request fields and decide issue/release this cycle.
   always_comb begin
      cur_port  = (state_q == OWN1);
      own_req   = cur_port ? bus.req1   : bus.req0;
      oth_req   = cur_port ? bus.req0   : bus.req1;
      own_we    = cur_port ? bus.we1    : bus.we0;
      own_lock  = cur_port ? bus.lock1  : bus.lock0;
      own_addr  = cur_port ? bus.addr1  : bus.addr0;
      own_wdata = cur_port ? bus.wdata1 : bus.wdata0;
      issue     = (state_q != IDLE) && own_req;
      hold_inc  = hold_q;
      if (issue && (hold_q < 8'(MAX_HOLD))) begin
         hold_inc = hold_q + 8'd1;
      end
      // The hold limit counts the access made this cycle, so the MAX_HOLD-th
      // access is the last one granted while the other port is waiting.
      rel = (state_q != IDLE) &&
            (!own_req || (issue && !own_lock) ||
             ((hold_inc == 8'(MAX_HOLD)) && oth_req));
   end

   // Next-state, round-robin pointer and hold counter.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      hold_d  = hold_inc;
      case (state_q)
         IDLE: begin
            hold_d = 8'd0;
            if (bus.req0 && bus.req1) begin
               state_d = rr_q ? OWN1 : OWN0;
            end else if (bus.req0) begin
               state_d = OWN0;
            end else if (bus.req1) begin
               state_d = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (rel) begin
               rr_d   = ~cur_port;
               hold_d = 8'd0;
               if (oth_req) begin
                  state_d = cur_port ? OWN0 : OWN1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory address/data follow the owner on an access and hold otherwise.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (issue) begin
         addr_d  = own_addr;
         wdata_d = own_wdata;
      end
   end

   // Arbitration state and last memory address/data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         hold_q  <= 8'd0;
         addr_q  <= '0;
         wdata_q <= 16'd0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Read-return pipe: tags each read with its port so data routes correctly
   // even after ownership has moved on.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rv_q <= '0;
         rp_q <= '0;
      end else begin
         rv_q[0] <= issue && !own_we;
         rp_q[0] <= cur_port;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rv_q[i] <= rv_q[i-1];
            rp_q[i] <= rp_q[i-1];
         end
      end
   end

   assign bus.gnt0      = (state_q == OWN0);
   assign bus.gnt1      = (state_q == OWN1);
   assign bus.mem_addr  = addr_d;
   assign bus.mem_wdata = wdata_d;
   assign bus.mem_wr_en = issue && own_we;
   assign bus.mem_rd_en = issue && !own_we;
   assign bus.rvalid0   = rv_q[RD_LATENCY-1] && !rp_q[RD_LATENCY-1];
   assign bus.rvalid1   = rv_q[RD_LATENCY-1] &&  rp_q[RD_LATENCY-1];
   assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, shadow-memory scoreboard, directed and random steps.
// Read data is checked against a shadow copy with the expected return cycle.
// Requesters hold req until granted, then move on to their next access.
module tb_mem_port_arbiter;

   localparam int AW     = 14;
   localparam int RD_LAT = 1;
   localparam int MH     = 16;
   localparam int DEPTH  = 1 << AW;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .RD_LATENCY(RD_LAT), .MAX_HOLD(MH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   function automatic logic [15:0] pat(input int a);
      return 16'(a * 40503) ^ 16'h5A5A;
   endfunction

   // Memory model: writes on the edge, read data appears RD_LAT cycles later.
   logic [15:0] mem     [DEPTH];
   bit          mem_set [DEPTH];
   logic [15:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.mem_wr_en) begin
         mem[bus.mem_addr]     <= bus.mem_wdata;
         mem_set[bus.mem_addr] <= 1'b1;
      end
      rd_pipe[0] <= mem_set[bus.mem_addr] ? mem[bus.mem_addr] : pat(int'(bus.mem_addr));
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   // Shadow memory and scoreboard
   logic [15:0] shadow [DEPTH];
   bit          sh_set [DEPTH];
   typedef struct { logic [15:0] d; int c; } exp_t;
   exp_t q0[$], q1[$];

   function automatic logic [15:0] sh_rd(input int a);
      return sh_set[a] ? shadow[a] : pat(a);
   endfunction

   int errors = 0, checks = 0, cyc = 0;
   int n_rv0 = 0, n_rv1 = 0, wait0 = 0, wait1 = 0;
   bit rand_phase = 0, hold_known = 0;
   logic [AW-1:0] last_addr;
   logic [15:0]   last_wd;
   logic s_gnt0, s_gnt1, s_rv0, s_rv1, s_wr, s_rd;
   logic [15:0] s_rdata, s_mwd;
   logic [AW-1:0] s_maddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Sample outputs mid-cycle, score them, then step to just after the next edge.
   task automatic tick();
      logic iss0, iss1, isw;
      int   a;
      exp_t e;
      @(negedge clk);
      cyc++;
      s_gnt0 = bus.gnt0;  s_gnt1 = bus.gnt1;
      s_rv0  = bus.rvalid0; s_rv1 = bus.rvalid1;
      s_wr   = bus.mem_wr_en; s_rd = bus.mem_rd_en;
      s_rdata = bus.rdata; s_maddr = bus.mem_addr; s_mwd = bus.mem_wdata;
      chk("gnt_mutex", s_gnt0 & s_gnt1, 0);
      iss0 = s_gnt0 && bus.req0;
      iss1 = s_gnt1 && bus.req1;
      chk("mem_wr_en", s_wr, (iss0 && bus.we0) || (iss1 && bus.we1));
      chk("mem_rd_en", s_rd, (iss0 && !bus.we0) || (iss1 && !bus.we1));
      if (s_rv0) begin
         if (q0.size() == 0) chk("rvalid0_unexpected", s_rv0, 0);
         else begin
            e = q0.pop_front();
            chk("rdata0", s_rdata, e.d);
            chk("rvalid0_latency", cyc, e.c + RD_LAT);
         end
         n_rv0++;
      end
      if (s_rv1) begin
         if (q1.size() == 0) chk("rvalid1_unexpected", s_rv1, 0);
         else begin
            e = q1.pop_front();
            chk("rdata1", s_rdata, e.d);
            chk("rvalid1_latency", cyc, e.c + RD_LAT);
         end
         n_rv1++;
      end
      if (iss0 || iss1) begin
         a   = iss0 ? int'(bus.addr0) : int'(bus.addr1);
         isw = iss0 ? bus.we0 : bus.we1;
         chk("mem_addr", s_maddr, a);
         chk("mem_wdata", s_mwd, iss0 ? bus.wdata0 : bus.wdata1);
         if (isw) begin
            shadow[a] = iss0 ? bus.wdata0 : bus.wdata1;
            sh_set[a] = 1'b1;
         end else if (iss0) q0.push_back('{sh_rd(a), cyc});
         else               q1.push_back('{sh_rd(a), cyc});
         last_addr  = s_maddr;
         last_wd    = s_mwd;
         hold_known = 1'b1;
      end else if (hold_known) begin
         chk("mem_addr_hold", s_maddr, last_addr);
         chk("mem_wdata_hold", s_mwd, last_wd);
      end
      wait0 = (bus.req0 && !s_gnt0) ? wait0 + 1 : 0;
      wait1 = (bus.req1 && !s_gnt1) ? wait1 + 1 : 0;
      if (rand_phase) begin
         chk("fair0", wait0 <= MH + 3, 1);
         chk("fair1", wait1 <= MH + 3, 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      q0.delete();
      q1.delete();
      hold_known = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $error("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p0n, p1n, first_g1, p0_at_g1, resume, n, g1c, holes, rv_s0, rv_s1;
      bit started, have0, have1;
      resetn = 1'b0;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.lock0 = 0; bus.lock1 = 0; bus.addr0 = '0; bus.addr1 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_rvalid0", bus.rvalid0, 0);
      chk("rst_rvalid1", bus.rvalid1, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      resetn = 1'b1;

      // Single read from port 0
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 14'h005;
      tick();
      chk("t1_idle_gnt0", s_gnt0, 0);
      chk("t1_idle_rd", s_rd, 0);
      tick();
      chk("t1_gnt0", s_gnt0, 1);
      chk("t1_rd_en", s_rd, 1);
      chk("t1_addr", s_maddr, 14'h005);
      bus.req0 = 0;
      tick();
      chk("t1_rvalid0", s_rv0, 1);
      chk("t1_rvalid1", s_rv1, 0);
      chk("t1_rdata", s_rdata, sh_rd(5));
      tick();
      chk("t1_released", s_gnt0, 0);

      // Alternating grants with both requesting, no lock
      do_reset();
      bus.lock0 = 0; bus.lock1 = 0; bus.we0 = 0; bus.we1 = 1;
      for (int c = 0; c < 7; c++) begin
         bus.req0 = 1; bus.req1 = 1;
         bus.addr0 = AW'(14'h200 + c); bus.addr1 = AW'(14'h300 + c);
         bus.wdata1 = 16'($urandom);
         tick();
         chk("t2_gnt0", s_gnt0, (c > 0) && (c % 2 == 1));
         chk("t2_gnt1", s_gnt1, (c > 0) && (c % 2 == 0));
      end
      bus.req0 = 0; bus.req1 = 0;
      repeat (3) tick();

      // Locked write burst of 20 on port 0, port 1 competes from cycle 3
      do_reset();
      p0n = 0; p1n = 0; first_g1 = -1; p0_at_g1 = -1; resume = -1;
      for (int c = 0; c < 60 && (p0n < 20 || p1n < 1); c++) begin
         bus.req0 = (p0n < 20); bus.we0 = 1; bus.lock0 = 1;
         bus.addr0 = AW'(14'h100 + p0n); bus.wdata0 = 16'(16'hC000 + p0n);
         bus.req1 = (c >= 3) && (p1n < 1); bus.we1 = 0; bus.lock1 = 0;
         bus.addr1 = 14'h100;
         tick();
         if (s_gnt0 && bus.req0) begin
            p0n++;
            if (first_g1 >= 0 && resume < 0) resume = c;
         end
         if (s_gnt1 && bus.req1) begin
            p1n++; first_g1 = c; p0_at_g1 = p0n;
         end
      end
      bus.req0 = 0; bus.req1 = 0;
      chk("t3_p0_before_handoff", p0_at_g1, MH);
      chk("t3_gnt1_cycle", first_g1, MH + 1);
      chk("t3_p0_resume_cycle", resume, MH + 2);
      chk("t3_p0_total", p0n, 20);
      chk("t3_p1_total", p1n, 1);
      repeat (3) tick();

      // Locked read burst of 40 on port 1 alone
      rv_s0 = n_rv0; rv_s1 = n_rv1;
      n = 0; g1c = 0; holes = 0; started = 0;
      for (int c = 0; c < 100 && n < 40; c++) begin
         bus.req1 = 1; bus.we1 = 0; bus.lock1 = 1; bus.addr1 = AW'(14'h100 + n);
         tick();
         if (s_gnt1) begin started = 1; g1c++; end
         else if (started) holes++;
         if (s_gnt1 && bus.req1) n++;
      end
      bus.req1 = 0;
      repeat (RD_LAT + 2) tick();
      chk("t4_accesses", n, 40);
      chk("t4_gnt1_cycles", g1c, 40);
      chk("t4_gnt1_holes", holes, 0);
      chk("t4_rvalid1_count", n_rv1 - rv_s1, 40);
      chk("t4_rvalid0_count", n_rv0 - rv_s0, 0);

      // Port 0 read in its last owned cycle, handoff to port 1
      do_reset();
      bus.req0 = 1; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 14'h105;
      bus.req1 = 1; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 14'h106;
      tick();
      chk("t5_idle", s_gnt0 | s_gnt1, 0);
      tick();
      chk("t5_gnt0", s_gnt0, 1);
      bus.req0 = 0;
      tick();
      chk("t5_gnt1", s_gnt1, 1);
      chk("t5_rvalid0", s_rv0, 1);
      chk("t5_rvalid1_low", s_rv1, 0);
      chk("t5_rdata0", s_rdata, sh_rd(32'h105));
      bus.req1 = 0;
      tick();
      chk("t5_rvalid1", s_rv1, 1);
      chk("t5_rvalid0_low", s_rv0, 0);
      chk("t5_rdata1", s_rdata, sh_rd(32'h106));
      repeat (2) tick();

      // Reset mid-burst with reads in flight
      for (int i = 0; i < 5; i++) begin
         bus.req1 = 1; bus.we1 = 0; bus.lock1 = 1; bus.addr1 = AW'(14'h110 + i);
         tick();
      end
      chk("t6_pre_gnt1", bus.gnt1, 1);
      chk("t6_pre_rvalid1", bus.rvalid1, 1);
      resetn = 1'b0;
      #1;
      chk("t6_gnt0", bus.gnt0, 0);
      chk("t6_gnt1", bus.gnt1, 0);
      chk("t6_rvalid0", bus.rvalid0, 0);
      chk("t6_rvalid1", bus.rvalid1, 0);
      chk("t6_wr_en", bus.mem_wr_en, 0);
      chk("t6_rd_en", bus.mem_rd_en, 0);
      bus.req1 = 0;
      q0.delete(); q1.delete(); hold_known = 0;
      repeat (2) tick();
      resetn = 1'b1;
      repeat (3) tick();
      chk("t6_post_rvalid1", s_rv1, 0);
      chk("t6_post_gnt1", s_gnt1, 0);
      bus.req0 = 1; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 14'h020;
      bus.req1 = 1; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 14'h021;
      tick();
      tick();
      chk("t6_first_gnt0", s_gnt0, 1);
      chk("t6_first_gnt1", s_gnt1, 0);
      bus.req0 = 0; bus.req1 = 0;
      repeat (3) tick();

      // Random traffic on a small address window
      rand_phase = 1; have0 = 0; have1 = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!have0 && $urandom_range(0, 3) != 0) begin
            have0 = 1; bus.we0 = 1'($urandom_range(0, 1));
            bus.addr0 = AW'($urandom_range(0, 15)); bus.wdata0 = 16'($urandom);
            bus.lock0 = 1'($urandom_range(0, 1));
         end
         if (!have1 && $urandom_range(0, 3) != 0) begin
            have1 = 1; bus.we1 = 1'($urandom_range(0, 1));
            bus.addr1 = AW'($urandom_range(0, 15)); bus.wdata1 = 16'($urandom);
            bus.lock1 = 1'($urandom_range(0, 1));
         end
         bus.req0 = have0; bus.req1 = have1;
         tick();
         if (s_gnt0 && bus.req0) have0 = 0;
         if (s_gnt1 && bus.req1) have1 = 0;
      end
      rand_phase = 0;
      bus.req0 = 0; bus.req1 = 0;
      repeat (RD_LAT + 3) tick();
      chk("final_q0_drained", q0.size(), 0);
      chk("final_q1_drained", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
